// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
// The watchdog counter width only matters when APB_ARB_TIMEOUT_EN is defined.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CNT_WIDTH = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_arb_rr_pick.sv
// Combinational round-robin selector: first requester at or after
// (last_grant + 1) mod NREQ.
module apb_arb_rr_pick
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one slave request port.
// Optional watchdog abort of unacknowledged transfers: define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IW            = idx_width(NREQ)
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic [NREQ*ADDR_WIDTH-1:0] m_addr,
  input  logic [NREQ-1:0]            m_wrreq,
  input  logic [NREQ-1:0]            m_rdreq,
  input  logic [NREQ*STRB_WIDTH-1:0] m_wstrb,
  input  logic [NREQ*DATA_WIDTH-1:0] m_wdata,
  output logic [DATA_WIDTH-1:0]      m_rdata,
  output logic [NREQ-1:0]            m_ack,
  output logic [NREQ-1:0]            m_error,
  output logic [ADDR_WIDTH-1:0]      s_addr,
  output logic [STRB_WIDTH-1:0]      s_wstrb,
  output logic [DATA_WIDTH-1:0]      s_wdata,
  output logic                       s_wrreq,
  output logic                       s_rdreq,
  input  logic [DATA_WIDTH-1:0]      s_rdata,
  input  logic                       s_ack,
  input  logic                       s_error,
  output logic [IW-1:0]              grant_id,
  output logic                       busy
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2 ||
      TIMEOUT_CYCLES >= (1 << TIMEOUT_CNT_WIDTH)) begin : g_bad_params
    $error("apb_req_arbiter: parameter out of range");
  end

  arb_state_t            state, next_state;
  logic [NREQ-1:0]       req_vec;
  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         last_grant;
  logic                  is_write;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;
  logic                  timeout;

  assign req_vec = m_wrreq | m_rdreq;

  apb_arb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req_vec),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  logic [TIMEOUT_CNT_WIDTH-1:0] wd_cnt;

  // Counts GRANT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)             wd_cnt <= '0;
    else if (state != GRANT)  wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (state == GRANT) &&
                   (wd_cnt == TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (pick_valid)        next_state = GRANT;
      GRANT:   if (s_ack || timeout)  next_state = RESP;
      RESP:                           next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // Capture registers; s_ack wins over a simultaneous watchdog expiry.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s_addr     <= '0;
      s_wstrb    <= '0;
      s_wdata    <= '0;
      s_wrreq    <= 1'b0;
      s_rdreq    <= 1'b0;
      is_write   <= 1'b0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      unique case (state)
        IDLE: if (pick_valid) begin
          grant_id   <= pick_idx;
          last_grant <= pick_idx;
          s_addr     <= m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          s_wdata    <= m_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          s_wstrb    <= m_wstrb[pick_idx*STRB_WIDTH +: STRB_WIDTH];
          is_write   <= m_wrreq[pick_idx];
          s_wrreq    <= m_wrreq[pick_idx];
          s_rdreq    <= ~m_wrreq[pick_idx];
        end
        GRANT: if (s_ack) begin
          s_wrreq <= 1'b0;
          s_rdreq <= 1'b0;
          rdata_q <= is_write ? '0 : s_rdata;
          error_q <= s_error;
        end else if (timeout) begin
          s_wrreq <= 1'b0;
          s_rdreq <= 1'b0;
          rdata_q <= '0;
          error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_ack   = '0;
    m_error = '0;
    m_rdata = '0;
    if (state == RESP) begin
      m_ack[grant_id]   = 1'b1;
      m_error[grant_id] = error_q;
      m_rdata           = rdata_q;
    end
  end

  assign busy = (state == GRANT) || (state == RESP);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter; the watchdog scenario runs only
// when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = 8;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_CYCLES = 8;
`else
  localparam int TO_CYCLES = 255;
`endif

  logic              hclk = 1'b0;
  logic              hresetn = 1'b0;
  logic [NREQ*AW-1:0] m_addr = '0;
  logic [NREQ-1:0]   m_wrreq = '0;
  logic [NREQ-1:0]   m_rdreq = '0;
  logic [NREQ*SW-1:0] m_wstrb = '0;
  logic [NREQ*DW-1:0] m_wdata = '0;
  logic [DW-1:0]     m_rdata;
  logic [NREQ-1:0]   m_ack;
  logic [NREQ-1:0]   m_error;
  logic [AW-1:0]     s_addr;
  logic [SW-1:0]     s_wstrb;
  logic [DW-1:0]     s_wdata;
  logic              s_wrreq;
  logic              s_rdreq;
  logic [DW-1:0]     s_rdata = '0;
  logic              s_ack = 1'b0;
  logic              s_error = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;

  apb_req_arbiter #(
    .NREQ           (NREQ),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .STRB_WIDTH     (SW),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .m_addr   (m_addr),
    .m_wrreq  (m_wrreq),
    .m_rdreq  (m_rdreq),
    .m_wstrb  (m_wstrb),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack),
    .m_error  (m_error),
    .s_addr   (s_addr),
    .s_wstrb  (s_wstrb),
    .s_wdata  (s_wdata),
    .s_wrreq  (s_wrreq),
    .s_rdreq  (s_rdreq),
    .s_rdata  (s_rdata),
    .s_ack    (s_ack),
    .s_error  (s_error),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   grant_cyc = 0;
  int   grant_cyc_prev = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge hclk) begin : monitor
    exp_t e;
    if (hresetn && m_ack != '0) begin
      if (sb.size() == 0) begin
        check_output("unexpected_ack", 64'(m_ack), 64'h0);
      end else begin
        e = sb.pop_front();
        check_output("m_ack", 64'(m_ack), 64'h1 << e.id);
        check_output("m_error", 64'(m_error), 64'(e.err) << e.id);
        check_output("m_rdata", m_rdata, e.rdata);
      end
    end
  end

  task automatic apply_stimulus(input int id, input bit wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
    m_addr[id*AW +: AW]  = addr;
    m_wdata[id*DW +: DW] = wdata;
    m_wstrb[id*SW +: SW] = strb;
    m_wrreq[id]          = wr;
    m_rdreq[id]          = !wr;
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge hclk);
      if (s_wrreq || s_rdreq) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Acts as the downstream slave for one transfer and queues the expected completion.
  task automatic serve_transfer(input int id, input bit wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int delay,
                                input logic [DW-1:0] rdata, input bit err,
                                input logic [NREQ-1:0] drop_mask);
    bit seen;
    int hi;
    wait_grant(seen);
    check_output("grant_seen", 64'(seen), 64'h1);
    if (!seen) return;
    grant_cyc_prev = grant_cyc;
    grant_cyc      = cyc;
    check_output("grant_id", 64'(grant_id), 64'(id));
    check_output("s_addr", 64'(s_addr), 64'(addr));
    check_output("s_wrreq", 64'(s_wrreq), 64'(wr));
    check_output("s_rdreq", 64'(s_rdreq), 64'(!wr));
    check_output("busy_grant", 64'(busy), 64'h1);
    if (wr) check_output("s_wdata", s_wdata, wdata);
    sb.push_back('{id, wr ? 64'h0 : rdata, err});
    hi = 1;
    repeat (delay - 1) begin
      @(negedge hclk);
      if (s_wrreq || s_rdreq) hi++;
    end
    s_ack   = 1'b1;
    s_rdata = rdata;
    s_error = err;
    @(negedge hclk);
    s_ack   = 1'b0;
    s_error = 1'b0;
    check_output("req_drop", 64'(s_wrreq | s_rdreq), 64'h0);
    check_output("req_len", 64'(hi), 64'(delay));
    m_wrreq = m_wrreq & ~drop_mask;
    m_rdreq = m_rdreq & ~drop_mask;
  endtask

  initial begin : timeout_guard
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    bit seen;
    int hi;
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    check_output("rst_m_ack", 64'(m_ack), 64'h0);
    check_output("rst_s_req", 64'({s_wrreq, s_rdreq}), 64'h0);
    check_output("rst_grant_id", 64'(grant_id), 64'h0);
    check_output("rst_busy", 64'(busy), 64'h0);
    check_output("rst_m_rdata", m_rdata, 64'h0);

    $display("[TB] single read, requester 2, ack in 2nd grant cycle");
    apply_stimulus(2, 1'b0, 32'h0000_0040, 64'h0, 8'h00);
    serve_transfer(2, 1'b0, 32'h0000_0040, 64'h0, 2, 64'hDEAD_BEEF, 1'b0, 4'b0100);

    $display("[TB] write with error, requester 1");
    apply_stimulus(1, 1'b1, 32'h0000_0100, 64'h1122_3344_5566_7788, 8'hFF);
    serve_transfer(1, 1'b1, 32'h0000_0100, 64'h1122_3344_5566_7788, 1, 64'hAAAA_5555, 1'b1, 4'b0010);
    @(negedge hclk);

    $display("[TB] stray ack in idle, then reset during grant");
    s_ack = 1'b1;
    @(negedge hclk);
    s_ack = 1'b0;
    @(negedge hclk);
    check_output("stray_busy", 64'(busy), 64'h0);
    check_output("stray_s_req", 64'({s_wrreq, s_rdreq}), 64'h0);
    apply_stimulus(3, 1'b0, 32'h0000_0300, 64'h0, 8'h00);
    wait_grant(seen);
    check_output("abort_grant_seen", 64'(seen), 64'h1);
    check_output("abort_grant_id", 64'(grant_id), 64'h3);
    hresetn = 1'b0;
    #1;
    check_output("abort_m_ack", 64'(m_ack), 64'h0);
    check_output("abort_s_req", 64'({s_wrreq, s_rdreq}), 64'h0);
    check_output("abort_s_addr", 64'(s_addr), 64'h0);
    check_output("abort_grant_id0", 64'(grant_id), 64'h0);
    check_output("abort_busy", 64'(busy), 64'h0);
    apply_stimulus(0, 1'b0, 32'h0000_0000, 64'h0, 8'h00);
    @(negedge hclk);
    hresetn = 1'b1;
    serve_transfer(0, 1'b0, 32'h0000_0000, 64'h0, 1, 64'h0000_0A0A, 1'b0, 4'b0001);
    serve_transfer(3, 1'b0, 32'h0000_0300, 64'h0, 1, 64'h0000_0B0B, 1'b0, 4'b1000);
    @(negedge hclk);

    $display("[TB] all requesters continuous from reset");
    hresetn = 1'b0;
    for (int i = 0; i < NREQ; i++)
      apply_stimulus(i, 1'b0, AW'(32'h10 * (i + 1)), 64'h0, 8'h00);
    @(negedge hclk);
    hresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serve_transfer(i % NREQ, 1'b0, AW'(32'h10 * ((i % NREQ) + 1)), 64'h0, 1,
                     64'h1000 + 64'(i), 1'b0, (i == 4) ? 4'hF : 4'h0);
      if (i > 0) check_output("rr_period", 64'(grant_cyc - grant_cyc_prev), 64'h3);
    end
    @(negedge hclk);

`ifdef APB_ARB_TIMEOUT_EN
    $display("[TB] watchdog abort, requester 1");
    apply_stimulus(1, 1'b0, 32'h0000_0500, 64'h0, 8'h00);
    wait_grant(seen);
    check_output("to_grant_seen", 64'(seen), 64'h1);
    if (seen) begin
      sb.push_back('{1, 64'h0, 1'b1});
      hi = 1;
      for (int n = 0; n < 20; n++) begin
        @(negedge hclk);
        if (s_wrreq || s_rdreq) hi++;
        else break;
      end
      check_output("to_req_len", 64'(hi), 64'(TO_CYCLES));
      m_rdreq[1] = 1'b0;
      @(negedge hclk);
      s_ack   = 1'b1;
      s_rdata = 64'hBAD0_BAD0;
      @(negedge hclk);
      s_ack = 1'b0;
      check_output("to_late_ack_busy", 64'(busy), 64'h0);
    end
    apply_stimulus(2, 1'b0, 32'h0000_0600, 64'h0, 8'h00);
    serve_transfer(2, 1'b0, 32'h0000_0600, 64'h0, 1, 64'h0000_0C0C, 1'b0, 4'b0100);
`endif

    repeat (3) @(negedge hclk);
    check_output("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
